// File: rtl/acc_share_pkg.sv
// Shared types and widths for the accumulator-sharing scheduler.
//   state_t    : scheduler FSM states
//   ACC_W      : accumulator datapath width
//   RES_W      : result width ({carry_count, acc})
//   onehot_idx : index of the set bit in a one-hot vector of up to 8 bits
package acc_share_pkg;

  localparam int unsigned ACC_W = 8;
  localparam int unsigned RES_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Encode a one-hot (or zero) vector to its bit index; zero maps to 0.
  function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/acc_share_sched_if.sv
// Requester / result bundle of the accumulator-sharing scheduler.
//   req       : per-requester job request (level, held until result taken)
//   opd_*     : per-requester operand stream, 8 bits per requester slice
//   opd_ready : operand accepted this cycle (one-hot or zero)
//   res_*     : shared result port with valid/ready handshake
// Modports: master = requester/consumer side, slave = scheduler.
interface acc_share_sched_if
  import acc_share_pkg::*;
#(
  parameter int unsigned NREQ = 4
);

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req;
  logic [ACC_W*NREQ-1:0] opd_data;
  logic [NREQ-1:0]       opd_valid;
  logic [NREQ-1:0]       opd_last;
  logic [NREQ-1:0]       opd_ready;
  logic                  res_valid;
  logic                  res_ready;
  logic [RES_W-1:0]      res_data;
  logic [IDW-1:0]        res_id;
  logic                  res_err;

  modport master (
    output req, opd_data, opd_valid, opd_last, res_ready,
    input  opd_ready, res_valid, res_data, res_id, res_err
  );

  modport slave (
    input  req, opd_data, opd_valid, opd_last, res_ready,
    output opd_ready, res_valid, res_data, res_id, res_err
  );

endinterface

// File: rtl/acc_share_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after ptr, wrapping past NREQ-1 back to 0.
//   req : request vector
//   ptr : highest-priority index
//   gnt : one-hot grant, zero when no request
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt
);

  logic found;
  int   idx;

  // Scan NREQ positions starting at ptr; first hit wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < int'(NREQ); off++) begin
      idx = int'(ptr) + off;
      if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/acc_share_sched.sv
// Round-robin scheduler sharing one external 8-bit accumulator between NREQ
// requesters. A job clears the accumulator, streams the owner's operands in,
// counts adder carry-outs and returns {carry_count, acc_q} with the owner id.
//   clk, clear : clock, synchronous active-high reset
//   bus        : requester operands/requests and shared result port
//   gnt        : current owner, one-hot, registered
//   acc_clear, acc_in, acc_cin : drive the accumulator instance
//   acc_q, acc_cout            : accumulator register value and adder carry
module acc_share_sched
  import acc_share_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned MAXLEN = 255
) (
  input  logic             clk,
  input  logic             clear,
  acc_share_sched_if.slave bus,
  output logic [NREQ-1:0]  gnt,
  output logic             acc_clear,
  output logic [ACC_W-1:0] acc_in,
  output logic             acc_cin,
  input  logic [ACC_W-1:0] acc_q,
  input  logic             acc_cout
);

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW  = $clog2(MAXLEN + 1);

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   g_idx;
  logic [IDW-1:0]   g_next;
  logic [ACC_W-1:0] carry_count;
  logic [CW-1:0]    op_count;
  logic [NREQ-1:0]  arb_gnt;
  logic [ACC_W-1:0] data_g;
  logic             req_g;
  logic             last_g;
  logic             accept;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (bus.req),
    .ptr (rr_ptr),
    .gnt (arb_gnt)
  );

  // Owner's operand slice and control bits, selected by the one-hot grant.
  always_comb begin
    data_g = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt[i]) data_g = bus.opd_data[i*ACC_W +: ACC_W];
    end
    req_g  = |(bus.req & gnt);
    last_g = |(bus.opd_last & gnt);
    // opd_ready is only ever set for the owner while in RUN.
    accept = |(bus.opd_valid & bus.opd_ready);
  end

  // Pointer moves past the owner when its job ends (result taken or abort).
  assign g_next = (g_idx == IDW'(NREQ - 1)) ? '0 : g_idx + IDW'(1);

  // Accumulator drive: add only accepted operands, so it holds otherwise.
  assign acc_clear    = clear | (state == CLR);
  assign acc_in       = (accept && !clear) ? data_g : '0;
  assign acc_cin      = 1'b0;
  assign bus.res_data = {carry_count, acc_q};

  // Scheduler FSM with registered grant, ready and result outputs.
  always_ff @(posedge clk) begin
    if (clear) begin
      state         <= IDLE;
      gnt           <= '0;
      g_idx         <= '0;
      rr_ptr        <= '0;
      carry_count   <= '0;
      op_count      <= '0;
      bus.opd_ready <= '0;
      bus.res_valid <= 1'b0;
      bus.res_err   <= 1'b0;
      bus.res_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            gnt   <= arb_gnt;
            g_idx <= IDW'(onehot_idx(8'(arb_gnt)));
            state <= CLR;
          end
        end
        CLR: begin
          carry_count   <= '0;
          op_count      <= '0;
          bus.opd_ready <= gnt;
          state         <= RUN;
        end
        RUN: begin
          if (!req_g) begin
            // Requester withdrew mid-job: drop it without a result.
            gnt           <= '0;
            bus.opd_ready <= '0;
            rr_ptr        <= g_next;
            state         <= IDLE;
          end else if (accept) begin
            carry_count <= carry_count + ACC_W'(acc_cout);
            op_count    <= op_count + CW'(1);
            if (last_g || (op_count == CW'(MAXLEN - 1))) begin
              bus.opd_ready <= '0;
              bus.res_valid <= 1'b1;
              bus.res_err   <= ~last_g;
              bus.res_id    <= g_idx;
              state         <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.res_err   <= 1'b0;
            gnt           <= '0;
            rr_ptr        <= g_next;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_share_sched.sv
// Directed bench for acc_share_sched with a behavioural accumulator.
module tb_acc_share_sched;
  import acc_share_pkg::*;

  localparam int unsigned NREQ = 4;

  logic            clk;
  logic            clear;
  logic [NREQ-1:0] gnt;
  logic            acc_clear;
  logic [7:0]      acc_in;
  logic            acc_cin;
  logic [7:0]      acc_q;
  logic            acc_cout;
  logic [8:0]      acc_sum;

  int checks = 0;
  int errors = 0;

  acc_share_sched_if #(.NREQ(NREQ)) bus ();

  acc_share_sched #(.NREQ(NREQ), .MAXLEN(4)) dut (
    .clk       (clk),
    .clear     (clear),
    .bus       (bus),
    .gnt       (gnt),
    .acc_clear (acc_clear),
    .acc_in    (acc_in),
    .acc_cin   (acc_cin),
    .acc_q     (acc_q),
    .acc_cout  (acc_cout)
  );

  // Accumulator instance model: 8-bit adder plus register.
  assign acc_sum  = {1'b0, acc_q} + {1'b0, acc_in} + 9'(acc_cin);
  assign acc_cout = acc_sum[8];
  always_ff @(posedge clk) begin
    if (acc_clear) acc_q <= 8'h00;
    else           acc_q <= acc_sum[7:0];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [7:0] v);
    bus.opd_data[i*8 +: 8] = v;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    tick();
    tick();
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    checks++;
    if (bus.opd_ready !== 4'b0000) begin errors++; $display("FAIL reset_opd_ready got %b want 0000", bus.opd_ready); end
    checks++;
    if (bus.res_valid !== 1'b0 || bus.res_err !== 1'b0 || bus.res_id !== 2'd0) begin
      errors++; $display("FAIL reset_res got v=%b e=%b id=%0d want 0 0 0", bus.res_valid, bus.res_err, bus.res_id);
    end
    checks++;
    if (acc_clear !== 1'b1 || acc_in !== 8'h00 || acc_cin !== 1'b0) begin
      errors++; $display("FAIL reset_acc got clr=%b in=%h cin=%b want 1 00 0", acc_clear, acc_in, acc_cin);
    end
    clear = 1'b0;
    tick();
    checks++;
    if (acc_clear !== 1'b0 || acc_q !== 8'h00) begin
      errors++; $display("FAIL reset_release got clr=%b q=%h want 0 00", acc_clear, acc_q);
    end
  endtask

  task automatic test_basic_job();
    bus.req = 4'b0001;
    tick();
    checks++;
    if (gnt !== 4'b0001 || bus.opd_ready !== 4'b0000) begin
      errors++; $display("FAIL basic_grant got gnt=%b rdy=%b want 0001 0000", gnt, bus.opd_ready);
    end
    bus.opd_valid = 4'b0001;
    set_data(0, 8'h10);
    tick();
    checks++;
    if (bus.opd_ready !== 4'b0001) begin errors++; $display("FAIL basic_ready got %b want 0001", bus.opd_ready); end
    tick();
    set_data(0, 8'h20);
    tick();
    set_data(0, 8'h30);
    bus.opd_last = 4'b0001;
    checks++;
    if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", bus.res_valid); end
    tick();
    bus.opd_valid = 4'b0000;
    bus.opd_last  = 4'b0000;
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h0060 || bus.res_id !== 2'd0 || bus.res_err !== 1'b0) begin
      errors++; $display("FAIL basic_result got v=%b d=%h id=%0d e=%b want 1 0060 0 0",
                         bus.res_valid, bus.res_data, bus.res_id, bus.res_err);
    end
    tick();
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h0060 || bus.opd_ready !== 4'b0000) begin
      errors++; $display("FAIL basic_hold got v=%b d=%h rdy=%b want 1 0060 0000", bus.res_valid, bus.res_data, bus.opd_ready);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    bus.req       = 4'b0000;
    checks++;
    if (bus.res_valid !== 1'b0 || gnt !== 4'b0000) begin
      errors++; $display("FAIL basic_release got v=%b gnt=%b want 0 0000", bus.res_valid, gnt);
    end
  endtask

  task automatic test_carry_count();
    bus.req = 4'b0100;
    tick();
    checks++;
    if (gnt !== 4'b0100) begin errors++; $display("FAIL carry_grant got %b want 0100", gnt); end
    bus.opd_valid = 4'b0100;
    set_data(2, 8'hFF);
    tick();
    tick();
    tick();
    set_data(2, 8'h02);
    bus.opd_last = 4'b0100;
    tick();
    bus.opd_valid = 4'b0000;
    bus.opd_last  = 4'b0000;
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h0200 || bus.res_id !== 2'd2 || bus.res_err !== 1'b0) begin
      errors++; $display("FAIL carry_result got v=%b d=%h id=%0d e=%b want 1 0200 2 0",
                         bus.res_valid, bus.res_data, bus.res_id, bus.res_err);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    bus.req       = 4'b0000;
  endtask

  task automatic test_round_robin();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int n = 0;
    logic [NREQ-1:0] prev;
    logic [NREQ-1:0] want;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 4; i++) set_data(i, 8'h01);
    bus.opd_valid = 4'b1111;
    bus.opd_last  = 4'b1111;
    bus.res_ready = 1'b1;
    bus.req       = 4'b1111;
    prev = '0;
    for (int cyc = 0; cyc < 60 && n < 5; cyc++) begin
      tick();
      checks++;
      if ($countones(gnt) > 1) begin errors++; $display("FAIL rr_onehot got %b want at most one bit", gnt); end
      if (bus.res_valid === 1'b1) begin
        checks++;
        if (bus.res_data !== 16'h0001) begin errors++; $display("FAIL rr_result got %h want 0001", bus.res_data); end
      end
      if (gnt !== 4'b0000 && prev === 4'b0000) begin
        want = 4'(1 << exp_order[n]);
        checks++;
        if (gnt !== want) begin errors++; $display("FAIL rr_order_%0d got %b want %b", n, gnt, want); end
        n++;
      end
      prev = gnt;
    end
    checks++;
    if (n != 5) begin errors++; $display("FAIL rr_timeout got %0d grants want 5", n); end
    bus.req       = 4'b0000;
    bus.opd_valid = 4'b0000;
    bus.opd_last  = 4'b0000;
    bus.res_ready = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (gnt !== 4'b0000 || bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL rr_drain got gnt=%b v=%b want 0000 0", gnt, bus.res_valid);
    end
  endtask

  task automatic test_maxlen();
    int accepts = 0;
    bus.req       = 4'b0010;
    bus.opd_valid = 4'b0010;
    set_data(1, 8'h80);
    for (int cyc = 0; cyc < 12; cyc++) begin
      tick();
      if (bus.res_valid === 1'b1) break;
      if (bus.opd_ready[1] === 1'b1) accepts++;
    end
    checks++;
    if (accepts != 4) begin errors++; $display("FAIL maxlen_accepts got %0d want 4", accepts); end
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_err !== 1'b1 || bus.res_data !== 16'h0200 || bus.res_id !== 2'd1) begin
      errors++; $display("FAIL maxlen_result got v=%b e=%b d=%h id=%0d want 1 1 0200 1",
                         bus.res_valid, bus.res_err, bus.res_data, bus.res_id);
    end
    tick();
    checks++;
    if (bus.opd_ready !== 4'b0000 || bus.res_data !== 16'h0200) begin
      errors++; $display("FAIL maxlen_fifth got rdy=%b d=%h want 0000 0200", bus.opd_ready, bus.res_data);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    bus.req       = 4'b0000;
    bus.opd_valid = 4'b0000;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.res_err !== 1'b0) begin
      errors++; $display("FAIL maxlen_release got v=%b e=%b want 0 0", bus.res_valid, bus.res_err);
    end
  endtask

  task automatic test_abort();
    bus.req = 4'b1000;
    tick();
    checks++;
    if (gnt !== 4'b1000) begin errors++; $display("FAIL abort_grant got %b want 1000", gnt); end
    bus.opd_valid = 4'b1000;
    set_data(3, 8'h11);
    tick();
    tick();
    tick();
    bus.opd_valid = 4'b0000;
    bus.req       = 4'b0001;
    tick();
    checks++;
    if (gnt !== 4'b0000 || bus.res_valid !== 1'b0 || bus.opd_ready !== 4'b0000) begin
      errors++; $display("FAIL abort_idle got gnt=%b v=%b rdy=%b want 0000 0 0000", gnt, bus.res_valid, bus.opd_ready);
    end
    bus.req = 4'b1001;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL abort_next_grant got %b want 0001", gnt); end
    checks++;
    if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL abort_no_result got %b want 0", bus.res_valid); end
  endtask

  task automatic test_clear_mid_job();
    // Requester 0 owns the accumulator from the previous task.
    bus.req = 4'b0001;
    tick();
    bus.opd_valid = 4'b0001;
    set_data(0, 8'h33);
    tick();
    clear = 1'b1;
    tick();
    checks++;
    if (acc_clear !== 1'b1 || gnt !== 4'b0000 || bus.res_valid !== 1'b0 || bus.opd_ready !== 4'b0000) begin
      errors++; $display("FAIL clear_cycle got clr=%b gnt=%b v=%b rdy=%b want 1 0000 0 0000",
                         acc_clear, gnt, bus.res_valid, bus.opd_ready);
    end
    clear         = 1'b0;
    bus.req       = 4'b0010;
    bus.opd_valid = 4'b0010;
    bus.opd_last  = 4'b0010;
    set_data(1, 8'h05);
    tick();
    checks++;
    if (gnt !== 4'b0010) begin errors++; $display("FAIL clear_regrant got %b want 0010", gnt); end
    tick();
    tick();
    bus.opd_valid = 4'b0000;
    bus.opd_last  = 4'b0000;
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h0005 || bus.res_id !== 2'd1 || bus.res_err !== 1'b0) begin
      errors++; $display("FAIL clear_new_job got v=%b d=%h id=%0d e=%b want 1 0005 1 0",
                         bus.res_valid, bus.res_data, bus.res_id, bus.res_err);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    bus.req       = 4'b0000;
    checks++;
    if (bus.res_valid !== 1'b0 || gnt !== 4'b0000) begin
      errors++; $display("FAIL clear_release got v=%b gnt=%b want 0 0000", bus.res_valid, gnt);
    end
  endtask

  initial begin
    clear         = 1'b1;
    bus.req       = '0;
    bus.opd_data  = '0;
    bus.opd_valid = '0;
    bus.opd_last  = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_basic_job();
    test_carry_count();
    test_round_robin();
    test_maxlen();
    test_abort();
    test_clear_mid_job();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
